// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch unit.
// S_FAULT exists only when INSTR_FETCH_FAULT_CHECK_EN is defined.
package fetch_pkg;
  localparam logic [11:0] ROM_BASE_HI      = 12'h080;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0800_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_STALL
`ifdef INSTR_FETCH_FAULT_CHECK_EN
    ,
    S_FAULT
`endif
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry prefetch FIFO of {pc, data}. Flush wins over push/pop.
// count_nxt exposes the post-edge occupancy so the fetcher can compute credit.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt
);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head      = mem_q[rd_q];
  assign count     = cnt_q;
  assign count_nxt = cnt_d;
endmodule

// File: rtl/instr_fetch.sv
// Instruction prefetch: sequential word reads, epoch-tagged responses, FIFO to decode.
// Optional ROM-window check enabled by INSTR_FETCH_FAULT_CHECK_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  output logic        write_enable,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] RESET_WADDR = {RESET_PC[31:20], 2'b00, RESET_PC[19:2]};

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic         req_q, req_d, epoch_q;
  logic [31:0]  req_pc_q, req_pc_d, rsp_pc_q;
  logic         req_ep_q, req_ep_d, rsp_ep_q, rsp_vld_q;
  logic         epoch_d, push, pop, inflight, issue;
  logic [31:0]  issue_pc;
  logic [CW:0]  credit;
  logic [CW-1:0] fifo_cnt, count_nxt;
  fetch_entry_t head, push_entry;

  assign issue_pc   = redirect_valid ? (redirect_pc & ~32'd3) : fetch_pc_q;
  assign epoch_d    = epoch_q ^ redirect_valid;
  assign pop        = instr_valid & instr_ready & ~redirect_valid;
  // Responses tagged with an older epoch belong to a flushed stream.
  assign push       = rsp_vld_q & (rsp_ep_q == epoch_q) & ~redirect_valid;
  assign push_entry = '{pc: rsp_pc_q, data: mem_rdata};
  // A request on the bus during a redirect is stale and needs no FIFO slot.
  assign inflight   = (state_q == S_FETCH) & ~redirect_valid;

`ifdef INSTR_FETCH_FAULT_CHECK_EN
  logic fault_q, fault_d, pc_ok, in_fault;
  assign pc_ok       = (issue_pc[31:20] == ROM_BASE_HI);
  assign in_fault    = (state_q == S_FAULT) & ~redirect_valid;
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    credit = {1'b0, count_nxt} + {{CW{1'b0}}, inflight};
`ifdef INSTR_FETCH_FAULT_CHECK_EN
    issue = ~in_fault & pc_ok & (credit < DEPTH_W);
`else
    issue = (credit < DEPTH_W);
`endif
    state_d    = issue ? S_FETCH : S_STALL;
    req_d      = issue;
    addr_d     = issue ? {issue_pc[31:20], 2'b00, issue_pc[19:2]} : addr_q;
    fetch_pc_d = issue ? issue_pc + 32'd4 : issue_pc;
    req_pc_d   = issue ? issue_pc : req_pc_q;
    req_ep_d   = issue ? epoch_d : req_ep_q;
`ifdef INSTR_FETCH_FAULT_CHECK_EN
    if (in_fault || !pc_ok) state_d = S_FAULT;
    // Sticky once the words fetched before the fault have drained.
    fault_d = (state_d == S_FAULT) &
              ((fault_q & ~redirect_valid) | ((count_nxt == '0) & ~inflight));
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_WADDR;
      req_q      <= 1'b0;
      epoch_q    <= 1'b0;
      req_pc_q   <= '0;
      req_ep_q   <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_pc_q   <= '0;
      rsp_ep_q   <= 1'b0;
`ifdef INSTR_FETCH_FAULT_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      epoch_q    <= epoch_d;
      req_pc_q   <= req_pc_d;
      req_ep_q   <= req_ep_d;
      rsp_vld_q  <= req_q;
      rsp_pc_q   <= req_pc_q;
      rsp_ep_q   <= req_ep_q;
`ifdef INSTR_FETCH_FAULT_CHECK_EN
      fault_q    <= fault_d;
`endif
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_cnt),
    .count_nxt (count_nxt)
  );

  assign mem_addr     = addr_q;
  assign mem_req      = req_q;
  assign write_enable = 1'b0;
  assign instr_valid  = (fifo_cnt != '0);
  assign instr_data   = head.data;
  assign instr_pc     = head.pc;
endmodule
